// File: rtl/arbitro_vetores_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : arbitro_vetores_if
// Description : Bus bundle for arbitro_vetores. It carries the two requester
//               valid/ready channels, the output channel and the per-requester
//               transfer counters.
// Revision    : 1.0 - initial release
// ============================================================================
interface arbitro_vetores_if #(
  parameter int CNT_W = 16
);
  // Requester 0
  logic             req0_valid;
  logic             req0_ready;
  logic [31:0]      req0_data;
  logic [1:0]       req0_modo;
  // Requester 1
  logic             req1_valid;
  logic             req1_ready;
  logic [31:0]      req1_data;
  logic [1:0]       req1_modo;
  // Output channel
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_data;
  logic             out_id;
  // Debug counters
  logic [CNT_W-1:0] cnt0;
  logic [CNT_W-1:0] cnt1;

  // Arbiter side
  modport slave (
    input  req0_valid, req0_data, req0_modo,
    input  req1_valid, req1_data, req1_modo,
    input  out_ready,
    output req0_ready, req1_ready,
    output out_valid, out_data, out_id,
    output cnt0, cnt1
  );

  // Requesters and consumer side
  modport master (
    output req0_valid, req0_data, req0_modo,
    output req1_valid, req1_data, req1_modo,
    output out_ready,
    input  req0_ready, req1_ready,
    input  out_valid, out_data, out_id,
    input  cnt0, cnt1
  );
endinterface
`default_nettype wire

// File: rtl/arbitro_vetores.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : arbitro_vetores
// Description : Two-requester round-robin arbiter feeding a nibble-permutation
//               datapath. The permuted word is held in a single output
//               register until the consumer takes it; a new word may replace
//               the old one in the same cycle it drains.
// Revision    : 1.0 - initial release
// ============================================================================
module arbitro_vetores #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  arbitro_vetores_if.slave bus
);

  // Output register occupancy
  localparam logic [0:0] LIVRE   = 1'b0;
  localparam logic [0:0] OCUPADO = 1'b1;

  localparam logic [1:0] MODO_IDENT = 2'b00;
  localparam logic [1:0] MODO_NIB   = 2'b01;
  localparam logic [1:0] MODO_BYTE  = 2'b10;

  logic [0:0]       estado_q, estado_d;
  logic             ultimo_q, ultimo_d;
  logic [31:0]      out_data_q, out_data_d;
  logic             out_id_q, out_id_d;
  logic [CNT_W-1:0] cnt0_q, cnt0_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d;

  logic             pode_aceitar;
  logic             grant;
  logic             aceita;
  logic [31:0]      palavra_sel;
  logic [1:0]       modo_sel;
  logic [31:0]      permutada;

  // Nibble permutation; nibble 7 is the most significant.
  function automatic logic [31:0] permuta(input logic [31:0] w, input logic [1:0] modo);
    logic [31:0] r;
    case (modo)
      MODO_IDENT: r = w;
      MODO_NIB:   r = {w[27:24], w[31:28], w[19:16], w[23:20],
                       w[11:8],  w[15:12], w[3:0],   w[7:4]};
      MODO_BYTE:  r = {w[7:0], w[15:8], w[23:16], w[31:24]};
      default:    r = {w[3:0],   w[7:4],   w[11:8],  w[15:12],
                       w[19:16], w[23:20], w[27:24], w[31:28]};
    endcase
    return r;
  endfunction

  // Round-robin grant: a lone requester wins, a conflict goes to the one not served last
  always_comb begin
    pode_aceitar = (estado_q == LIVRE) || bus.out_ready;
    if (bus.req0_valid && bus.req1_valid) begin
      grant = ~ultimo_q;
    end else begin
      grant = bus.req1_valid;
    end
    aceita      = pode_aceitar && (bus.req0_valid || bus.req1_valid);
    palavra_sel = grant ? bus.req1_data : bus.req0_data;
    modo_sel    = grant ? bus.req1_modo : bus.req0_modo;
    permutada   = permuta(palavra_sel, modo_sel);
  end

  // FSM state register; reset drops any in-flight word immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q <= LIVRE;
    end else begin
      estado_q <= estado_d;
    end
  end

  // FSM next state: a transfer always fills the register, a drain alone empties it
  always_comb begin
    estado_d = estado_q;
    case (estado_q)
      LIVRE: begin
        if (aceita) estado_d = OCUPADO;
      end
      OCUPADO: begin
        if (aceita) begin
          estado_d = OCUPADO;
        end else if (bus.out_ready) begin
          estado_d = LIVRE;
        end
      end
      default: estado_d = LIVRE;
    endcase
  end

  // FSM outputs: occupancy flag and the single-hot ready pair
  always_comb begin
    bus.out_valid  = (estado_q == OCUPADO);
    bus.req0_ready = aceita && !grant;
    bus.req1_ready = aceita && grant;
  end

  // Datapath next values: load on accept, otherwise hold (data kept after drain)
  always_comb begin
    out_data_d = out_data_q;
    out_id_d   = out_id_q;
    ultimo_d   = ultimo_q;
    cnt0_d     = cnt0_q;
    cnt1_d     = cnt1_q;
    if (aceita) begin
      out_data_d = permutada;
      out_id_d   = grant;
      ultimo_d   = grant;
      if (grant) begin
        cnt1_d = cnt1_q + CNT_W'(1);
      end else begin
        cnt0_d = cnt0_q + CNT_W'(1);
      end
    end
  end

  // Datapath registers; ultimo resets to 1 so requester 0 wins the first conflict
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q <= 32'h0;
      out_id_q   <= 1'b0;
      ultimo_q   <= 1'b1;
      cnt0_q     <= '0;
      cnt1_q     <= '0;
    end else begin
      out_data_q <= out_data_d;
      out_id_q   <= out_id_d;
      ultimo_q   <= ultimo_d;
      cnt0_q     <= cnt0_d;
      cnt1_q     <= cnt1_d;
    end
  end

  // Drive registered outputs onto the bus
  always_comb begin
    bus.out_data = out_data_q;
    bus.out_id   = out_id_q;
    bus.cnt0     = cnt0_q;
    bus.cnt1     = cnt1_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_arbitro_vetores.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_arbitro_vetores
// Description : Self-checking bench for arbitro_vetores. A 16-bit-counter
//               instance is driven directly; a 4-bit-counter instance mirrors
//               the same stimulus so counter wrap is observable.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_arbitro_vetores;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  arbitro_vetores_if #(.CNT_W(16)) ifm ();
  arbitro_vetores_if #(.CNT_W(4))  ifw ();

  arbitro_vetores #(.CNT_W(16)) dut   (.clk(clk), .rst_n(rst_n), .bus(ifm));
  arbitro_vetores #(.CNT_W(4))  dut_w (.clk(clk), .rst_n(rst_n), .bus(ifw));

  // Narrow instance sees the same requests as the wide one
  assign ifw.req0_valid = ifm.req0_valid;
  assign ifw.req0_data  = ifm.req0_data;
  assign ifw.req0_modo  = ifm.req0_modo;
  assign ifw.req1_valid = ifm.req1_valid;
  assign ifw.req1_data  = ifm.req1_data;
  assign ifw.req1_modo  = ifm.req1_modo;
  assign ifw.out_ready  = ifm.out_ready;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nome, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nome, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit          m_valid;
  logic [31:0] m_data;
  bit          m_id;
  bit          m_ult;
  int          m_cnt[2];
  int          m_cntw[2];

  // Output nibble i takes input nibble (i XOR k); k = 0,1,6,7 per mode
  function automatic logic [31:0] ref_perm(input logic [31:0] w, input logic [1:0] modo);
    int          k;
    int          src;
    logic [31:0] r;
    case (modo)
      2'd0:    k = 0;
      2'd1:    k = 1;
      2'd2:    k = 6;
      default: k = 7;
    endcase
    r = 32'h0;
    for (int i = 0; i < 8; i++) begin
      src = i ^ k;
      r[i*4 +: 4] = w[src*4 +: 4];
    end
    return r;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_data  = 32'h0;
    m_id    = 1'b0;
    m_ult   = 1'b1;
    m_cnt   = '{0, 0};
    m_cntw  = '{0, 0};
  endtask

  task automatic drive(input bit v0, input logic [31:0] d0, input logic [1:0] m0,
                       input bit v1, input logic [31:0] d1, input logic [1:0] m1,
                       input bit ordy);
    ifm.req0_valid = v0;
    ifm.req0_data  = d0;
    ifm.req0_modo  = m0;
    ifm.req1_valid = v1;
    ifm.req1_data  = d1;
    ifm.req1_modo  = m1;
    ifm.out_ready  = ordy;
  endtask

  task automatic check_outputs();
    chk("out_valid", ifm.out_valid, m_valid);
    chk("out_data",  ifm.out_data,  m_data);
    chk("out_id",    ifm.out_id,    m_id);
    chk("cnt0",      ifm.cnt0,      m_cnt[0]);
    chk("cnt1",      ifm.cnt1,      m_cnt[1]);
    chk("cnt0_w4",   ifw.cnt0,      m_cntw[0]);
    chk("cnt1_w4",   ifw.cnt1,      m_cntw[1]);
  endtask

  // One clock of stimulus, called at posedge+1; checks readys mid-cycle and state after the edge
  task automatic step(input bit v0, input logic [31:0] d0, input logic [1:0] m0,
                      input bit v1, input logic [31:0] d1, input logic [1:0] m1,
                      input bit ordy, output bit acc0, output bit acc1);
    bit pa, g, acc;
    drive(v0, d0, m0, v1, d1, m1, ordy);
    pa   = !m_valid || ordy;
    g    = (v0 && v1) ? !m_ult : v1;
    acc  = pa && (v0 || v1);
    acc0 = acc && !g;
    acc1 = acc && g;
    #3;
    chk("req0_ready", ifm.req0_ready, acc0);
    chk("req1_ready", ifm.req1_ready, acc1);
    @(posedge clk);
    if (acc) begin
      m_valid     = 1'b1;
      m_data      = g ? ref_perm(d1, m1) : ref_perm(d0, m0);
      m_id        = g;
      m_ult       = g;
      m_cnt[g]    = (m_cnt[g] + 1) % 65536;
      m_cntw[g]   = (m_cntw[g] + 1) % 16;
    end else if (ordy) begin
      m_valid = 1'b0;
    end
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    drive(1'b0, 32'h0, 2'd0, 1'b0, 32'h0, 2'd0, 1'b0);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit          rst_before;
    bit          v0;
    logic [31:0] d0;
    logic [1:0]  m0;
    bit          v1;
    logic [31:0] d1;
    logic [1:0]  m1;
    bit          ordy;
    bit          e_r0;
    bit          e_r1;
    bit          e_ov;
    logic [31:0] e_od;
    bit          e_id;
    int          e_c0;
    int          e_c1;
  } vec_t;

  vec_t tab[12];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit a0, a1;
    bit          p_v[2];
    logic [31:0] p_d[2];
    logic [1:0]  p_m[2];
    bit          ordy;

    // Modes from requester 0, then a fairness run after a fresh reset, then drain
    tab[0]  = '{0, 1, 32'h12345678, 2'd0, 0, 32'h0,        2'd0, 1, 1, 0, 1, 32'h12345678, 0, 1, 0};
    tab[1]  = '{0, 1, 32'h12345678, 2'd1, 0, 32'h0,        2'd0, 1, 1, 0, 1, 32'h21436587, 0, 2, 0};
    tab[2]  = '{0, 1, 32'h12345678, 2'd2, 0, 32'h0,        2'd0, 1, 1, 0, 1, 32'h78563412, 0, 3, 0};
    tab[3]  = '{0, 1, 32'h12345678, 2'd3, 0, 32'h0,        2'd0, 1, 1, 0, 1, 32'h87654321, 0, 4, 0};
    tab[4]  = '{1, 1, 32'h12345678, 2'd1, 1, 32'hCAFEBABE, 2'd3, 1, 1, 0, 1, 32'h21436587, 0, 1, 0};
    tab[5]  = '{0, 1, 32'h12345678, 2'd1, 1, 32'hCAFEBABE, 2'd3, 1, 0, 1, 1, 32'hEBABEFAC, 1, 1, 1};
    tab[6]  = '{0, 1, 32'h12345678, 2'd1, 1, 32'hCAFEBABE, 2'd3, 1, 1, 0, 1, 32'h21436587, 0, 2, 1};
    tab[7]  = '{0, 1, 32'h12345678, 2'd1, 1, 32'hCAFEBABE, 2'd3, 1, 0, 1, 1, 32'hEBABEFAC, 1, 2, 2};
    tab[8]  = '{0, 1, 32'h12345678, 2'd1, 1, 32'hCAFEBABE, 2'd3, 1, 1, 0, 1, 32'h21436587, 0, 3, 2};
    tab[9]  = '{0, 1, 32'h12345678, 2'd1, 1, 32'hCAFEBABE, 2'd3, 1, 0, 1, 1, 32'hEBABEFAC, 1, 3, 3};
    tab[10] = '{0, 0, 32'h0,        2'd0, 0, 32'h0,        2'd0, 1, 0, 0, 0, 32'hEBABEFAC, 1, 3, 3};
    tab[11] = '{0, 0, 32'h0,        2'd0, 0, 32'h0,        2'd0, 0, 0, 0, 0, 32'hEBABEFAC, 1, 3, 3};

    // Reset state
    rst_n = 1'b0;
    do_reset();
    chk("rst out_valid",  ifm.out_valid,  0);
    chk("rst out_data",   ifm.out_data,   0);
    chk("rst out_id",     ifm.out_id,     0);
    chk("rst cnt0",       ifm.cnt0,       0);
    chk("rst cnt1",       ifm.cnt1,       0);
    chk("rst req0_ready", ifm.req0_ready, 0);
    chk("rst req1_ready", ifm.req1_ready, 0);

    // Directed table
    for (int i = 0; i < 12; i++) begin
      if (tab[i].rst_before) do_reset();
      drive(tab[i].v0, tab[i].d0, tab[i].m0, tab[i].v1, tab[i].d1, tab[i].m1, tab[i].ordy);
      #3;
      chk($sformatf("tab%0d req0_ready", i), ifm.req0_ready, tab[i].e_r0);
      chk($sformatf("tab%0d req1_ready", i), ifm.req1_ready, tab[i].e_r1);
      @(posedge clk);
      #1;
      chk($sformatf("tab%0d out_valid", i), ifm.out_valid, tab[i].e_ov);
      chk($sformatf("tab%0d out_data", i),  ifm.out_data,  tab[i].e_od);
      chk($sformatf("tab%0d out_id", i),    ifm.out_id,    tab[i].e_id);
      chk($sformatf("tab%0d cnt0", i),      ifm.cnt0,      tab[i].e_c0);
      chk($sformatf("tab%0d cnt1", i),      ifm.cnt1,      tab[i].e_c1);
    end

    // Backpressure: first word held for 4 stalled cycles, then replaced in the release cycle
    do_reset();
    step(0, 32'h0, 2'd0, 1, 32'h0000FFFF, 2'd2, 0, a0, a1);
    chk("bp first accept", a1, 1);
    chk("bp out_data", ifm.out_data, 32'hFFFF0000);
    for (int i = 0; i < 4; i++) begin
      step(0, 32'h0, 2'd0, 1, 32'h11223344, 2'd0, 0, a0, a1);
      chk("bp stall out_valid", ifm.out_valid, 1);
      chk("bp stall out_data",  ifm.out_data,  32'hFFFF0000);
      chk("bp stall cnt1",      ifm.cnt1,      1);
    end
    step(0, 32'h0, 2'd0, 1, 32'h11223344, 2'd0, 1, a0, a1);
    chk("bp release out_data", ifm.out_data, 32'h11223344);
    chk("bp release cnt1",     ifm.cnt1,     2);
    chk("bp release out_valid", ifm.out_valid, 1);

    // Reset mid-operation while OCUPADO and stalled
    step(0, 32'h0, 2'd0, 0, 32'h0, 2'd0, 0, a0, a1);
    rst_n = 1'b0;
    #1;
    chk("async rst out_valid", ifm.out_valid, 0);
    chk("async rst out_data",  ifm.out_data,  0);
    chk("async rst cnt1",      ifm.cnt1,      0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    step(0, 32'h0, 2'd0, 0, 32'h0, 2'd0, 1, a0, a1);
    chk("post rst no reemit", ifm.out_valid, 0);
    step(0, 32'h0, 2'd0, 0, 32'h0, 2'd0, 0, a0, a1);
    chk("post rst no reemit 2", ifm.out_valid, 0);

    // Counter wrap on the 4-bit instance
    do_reset();
    for (int i = 0; i < 17; i++) begin
      step(1, $urandom, 2'($urandom_range(0, 3)), 0, 32'h0, 2'd0, 1, a0, a1);
    end
    chk("wrap cnt0_w4", ifw.cnt0, 1);
    chk("wrap cnt0_w16", ifm.cnt0, 17);

    // Randomized traffic against the model; a waiting requester keeps its word stable
    do_reset();
    p_v = '{0, 0};
    p_d = '{32'h0, 32'h0};
    p_m = '{2'd0, 2'd0};
    for (int n = 0; n < 400; n++) begin
      for (int r = 0; r < 2; r++) begin
        if (!p_v[r]) begin
          p_v[r] = ($urandom_range(0, 9) < 7);
          p_d[r] = $urandom;
          p_m[r] = 2'($urandom_range(0, 3));
        end
      end
      ordy = ($urandom_range(0, 9) < 7);
      step(p_v[0], p_d[0], p_m[0], p_v[1], p_d[1], p_m[1], ordy, a0, a1);
      if (a0) p_v[0] = 1'b0;
      if (a1) p_v[1] = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/arbitro_vetores.md
# arbitro_vetores

Two-requester controller for the nibble-permutation datapath. Each requester offers a 32-bit word plus a 2-bit permutation mode over a valid/ready handshake. The block arbitrates round-robin, applies the selected nibble permutation, and holds the result in a single output register until the consumer accepts it. Per-requester transfer counters support debug and bench scoreboarding.

## Interface
- CNT_W, 16, width of each per-requester transfer counter
- clk  in  1  single clock, all state updates on rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- req0_valid  in  1  requester 0 has a word
- req0_ready  out  1  requester 0 word accepted this cycle
- req0_data  in  32  requester 0 word
- req0_modo  in  2  requester 0 permutation mode
- req1_valid / req1_ready / req1_data / req1_modo  same as requester 0, for requester 1
- out_valid  out  1  output register holds a result
- out_ready  in  1  consumer accepts the result
- out_data  out  32  permuted word
- out_id  out  1  requester that produced out_data
- cnt0, cnt1  out  CNT_W  accepted-transfer counts per requester

## Operation
- Nibble notation: n7 = data[31:28] … n0 = data[3:0]; results are listed MSB first.
- modo 00: identity.
- modo 01: {n6,n7,n4,n5,n2,n3,n0,n1}, a nibble swap inside each byte.
- modo 10: {n1,n0,n3,n2,n5,n4,n7,n6}, a byte reverse.
- modo 11: {n0,n1,n2,n3,n4,n5,n6,n7}, a full nibble reverse.
- FSM, two states:
  - LIVRE: output register empty, out_valid=0.
  - OCUPADO: out_valid=1.
- pode_aceitar = (LIVRE) or (OCUPADO and out_ready).
- Arbitration:
  - Pointer `ultimo` records the last granted requester.
  - If exactly one reqX_valid is high, that requester is granted.
  - If both are high, the requester not equal to `ultimo` is granted.
  - Grant is only effective when pode_aceitar=1.
- reqX_ready = grantX and pode_aceitar. It is combinational from the valids and out_ready, and at most one ready is high per cycle. Requesters must not make valid depend on ready.
- On an accepted transfer:
  - out_data ← permuted word and out_id ← granted index.
  - `ultimo` ← granted index.
  - cntX += 1, wrapping modulo 2^CNT_W.
  - State → OCUPADO.
- OCUPADO with out_ready=1 and no new transfer: state → LIVRE. out_data and out_id keep their last values.
- OCUPADO with out_ready=0: out_data, out_id and out_valid are held stable, and both readys are 0.
- Requester holding valid while not granted: it must keep its data and modo stable. The block does not latch the request.
- Reset values: out_valid=0, out_data=0, out_id=0, cnt0=0, cnt1=0, `ultimo`=1 (so requester 0 wins the first conflict), state LIVRE.
- Reset mid-operation: the in-flight result is discarded immediately (asynchronous) and is never re-presented.

## Timing
- Latency: a word accepted at rising edge k appears with out_valid=1 during cycle k+1.
- Throughput: one word per cycle when out_ready stays 1 and a requester is valid. A back-to-back replace in OCUPADO has no bubble.
- Fairness: with both requesters continuously valid and out_ready=1, grants alternate 0,1,0,1… starting with 0 after reset.
- Simultaneous accept and drain in the same cycle: the new word replaces the old one. out_valid stays 1, and the counter of the new requester increments exactly once.
- Counter wrap: at 2^CNT_W−1 the next accept gives 0, with no flag.
- Asynchronous reset: assert forces reset values without a clock. Deassert must be synchronised externally to clk.

## Test plan
- Reset check: hold rst_n=0 for 3 cycles, then release -> out_valid=0, out_data=0, cnt0=cnt1=0, req0_ready=req1_ready=0 while both valids are 0.
- Modes: requester 0 sends 0x12345678 with modo 00/01/10/11, out_ready=1 -> out_data is 0x12345678, 0x21436587, 0x78563412, 0x87654321 on consecutive cycles, out_id=0, cnt0=4.
- Fairness: both requesters valid for 6 cycles, out_ready=1 -> grant order 0,1,0,1,0,1, cnt0=cnt1=3, out_id alternates.
- Backpressure: out_ready=0 for 5 cycles with requester 1 valid -> first word held stable with out_valid=1, req1_ready=0 for the 4 subsequent cycles, cnt1=1. Raising out_ready -> next word accepted in that same cycle.
- Reset mid-operation: pull rst_n low while OCUPADO with out_ready=0 -> out_valid drops to 0 before the next edge, counters read 0, and the word is not re-emitted after release.
- Wrap: CNT_W=4, 17 accepts from requester 0 -> cnt0=1.
